// File: rtl/shift_reg_tap_ctrl_if.sv
// RAM-side bus of the delay-line controller: write port, read port and registered read data.
// ram_we/ram_re are single-cycle strobes with no backpressure; ram_rd is valid the cycle after ram_re.
interface shift_reg_tap_ctrl_if #(
    parameter int DSIZE = 25,
    parameter int ASIZE = 8
);
    logic [ASIZE-1:0] ram_wa;
    logic [DSIZE-1:0] ram_wd;
    logic             ram_we;
    logic [ASIZE-1:0] ram_ra;
    logic             ram_re;
    logic [DSIZE-1:0] ram_rd;

    modport master (
        output ram_wa, ram_wd, ram_we, ram_ra, ram_re,
        input  ram_rd
    );

    modport slave (
        input  ram_wa, ram_wd, ram_we, ram_ra, ram_re,
        output ram_rd
    );
endinterface

// File: rtl/shift_reg_tap_ctrl.sv
// Address/fill controller for a RAM-backed variable-length delay line.
// Optional ZERO_FILL_EN: Q is loaded with 0 instead of stale RAM data while filling.
module shift_reg_tap_ctrl #(
    parameter int DSIZE  = 25,
    parameter int WDEPTH = 256,
    parameter int ASIZE  = $clog2(WDEPTH)
) (
    input  logic                  clk,
    input  logic                  Reset_n,
    input  logic                  ce,
    input  logic [DSIZE-1:0]      Din,
    input  logic [ASIZE-1:0]      Len,
    input  logic                  len_ld,
    shift_reg_tap_ctrl_if.master  ram,
    output logic [DSIZE-1:0]      Q,
    output logic                  q_valid,
    output logic                  busy,
    output logic                  dbg_state
);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state, state_nx;
    logic [ASIZE-1:0] wp;
    logic [ASIZE-1:0] len_r;
    logic [ASIZE-1:0] len_new;
    logic [ASIZE-1:0] fill_cnt, fill_cnt_nx;
    logic             rd_pend;
    logic             rd_pend_vld;

    assign len_new = (Len == '0) ? ASIZE'(1) : Len;

    // Strobes are gated by reset so the RAM sees no access while held in reset.
    assign ram.ram_we = ce & Reset_n;
    assign ram.ram_re = ce & Reset_n;
    assign ram.ram_wa = wp;
    assign ram.ram_wd = Din;
    assign ram.ram_ra = wp - len_r;

    assign busy      = (state == FILL);
    assign dbg_state = state;

    // A ce coinciding with len_ld belongs to the old stream and is not counted.
    always_comb begin
        state_nx    = state;
        fill_cnt_nx = fill_cnt;
        if (len_ld) begin
            state_nx    = FILL;
            fill_cnt_nx = len_new;
        end else if (ce && (state == FILL)) begin
            fill_cnt_nx = fill_cnt - ASIZE'(1);
            if (fill_cnt == ASIZE'(1)) begin
                state_nx = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= FILL;
            fill_cnt    <= ASIZE'(1);
            len_r       <= ASIZE'(1);
            wp          <= '0;
            rd_pend     <= 1'b0;
            rd_pend_vld <= 1'b0;
            Q           <= '0;
            q_valid     <= 1'b0;
        end else begin
            state    <= state_nx;
            fill_cnt <= fill_cnt_nx;
            if (len_ld) begin
                len_r <= len_new;
            end
            if (ce) begin
                wp <= wp + ASIZE'(1);
            end
            // Validity is decided by the state at read time, one cycle before Q loads.
            rd_pend     <= ce;
            rd_pend_vld <= ce && (state == RUN) && !len_ld;
            if (rd_pend) begin
`ifdef ZERO_FILL_EN
                Q <= rd_pend_vld ? ram.ram_rd : '0;
`else
                Q <= ram.ram_rd;
`endif
                q_valid <= rd_pend_vld;
            end
            if (len_ld) begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/shift_reg_tap_ctrl.md
Name: shift_reg_tap_ctrl

Overview:
- Address/sequencing controller for the RAM-backed variable-length delay line used in the DDC receiver datapath.
- Owns the circular write pointer, derives the read address from a run-time programmable tap length, and drives a simple dual-port block RAM.
- Registers the RAM output and gates it with a fill state machine so downstream logic sees valid data only once the line holds L real samples.
- Handles tap-length reloads mid-stream.

Parameters:
- DSIZE, 25, sample width in bits.
- WDEPTH, 256, RAM depth in words (power of two).
- ASIZE, $clog2(WDEPTH), address width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- ce  input  1  sample enable; Din accepted when high.
- Din  input  DSIZE  input sample.
- Len  input  ASIZE  requested delay in samples; legal range 1..WDEPTH-1.
- len_ld  input  1  one-cycle pulse; latch Len.
- ram_wa  output  ASIZE  RAM write address.
- ram_wd  output  DSIZE  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_ra  output  ASIZE  RAM read address.
- ram_re  output  1  RAM read enable.
- ram_rd  input  DSIZE  RAM read data; registered RAM, valid 1 cycle after ram_re.
- Q  output  DSIZE  delayed sample.
- q_valid  output  1  Q holds a true sample delayed by L.
- busy  output  1  high in FILL state.

Behaviour:
- Reset (async, Reset_n=0): wp=0, L=1, state=FILL, fill_cnt=1, Q=0, q_valid=0, ram_we=0, ram_re=0, busy=1. RAM contents are not cleared.
- Len=0 is clamped to 1 when latched. The L register is ASIZE bits wide, so values cannot exceed WDEPTH-1.
- Per accepted sample (ce=1):
  - Combinational outputs: ram_we=1, ram_wa=wp, ram_wd=Din.
  - Read side, same cycle: ram_re=1, ram_ra=(wp-L) mod WDEPTH.
  - wp increments mod WDEPTH, wrapping from WDEPTH-1 to 0.
- With ce=0: ram_we=0, ram_re=0, wp, Q and q_valid hold.
- Output register:
  - Cycle after a ce: Q<=ram_rd.
  - Q therefore equals the Din accepted L ce-events earlier.
  - Latency from ce to Q update: 1 clk.
- Read/write never collide, since L>=1 implies ra!=wa.
- State machine:
  - FILL:
    - Each ce decrements fill_cnt.
    - When fill_cnt reaches 0 on a ce, go to RUN.
    - q_valid rises with the Q update of the next ce after that, i.e. the first sample at least L old.
    - q_valid=0 throughout FILL.
  - RUN: q_valid=1 from the first post-fill Q update; stays high while in RUN.
- len_ld (either state):
  - Latches L<=max(Len,1) and sets fill_cnt<=new L.
  - Moves to FILL and drops q_valid next cycle.
  - A ce in the same cycle as len_ld uses the old L for ram_ra and still writes.
  - That ce does not decrement the new fill_cnt.
  - len_ld during FILL restarts the fill with the new length.
  - wp is never reset by len_ld.
- busy = (state==FILL).
- Reset asserted mid-operation: immediate async return to reset values. Resumption needs L fresh ce samples before q_valid.

Optional Feature:
- Macro: ZERO_FILL_EN.
- Defined: during FILL, Q is forced to 0 on each update instead of ram_rd. This masks stale RAM contents.
- Undefined: Q always loads ram_rd, and only q_valid marks invalid data.
- Addressing, latency and q_valid timing are identical in both builds.

Test Plan:
- Reset, then Len=4 with len_ld; ce=1 continuously, Din counting 0,1,2,… → ram_ra=wp-4 mod 256. After the 5th ce, Q=0, then 1, 2, … (Q=Din−4). q_valid rises with Q=0; busy low thereafter.
- Length change mid-stream: Len=15 with len_ld after 1500 ns, same cycle as a ce → that ce reads with L=4. q_valid low for 15 samples, then Q=Din−15. wp continuous, no skip.
- Wrap-around: run >600 samples with L=15 → ram_wa wraps 255→0, ram_ra wraps correctly. Q stays Din−15 across the wrap with no glitch.
- Gapped ce (1 in 3 cycles), L=4 → Q updates exactly one clk after each ce and holds otherwise. Q equals the sample 4 ce-events earlier.
- Reset pulse (100 ns) mid-stream → outputs 0 immediately, L=1. The second ce after release raises q_valid with Q=first post-reset Din. Len=0 load → behaves as L=1.
- ZERO_FILL_EN build, repeat the Len 4→15 change → Q=0 throughout FILL. Without the macro, Q shows prior RAM data while q_valid=0.
